// File: rtl/petris_pkg.sv
// petris_pkg: board geometry, colour type and arbiter state shared by the board RAM blocks
package petris_pkg;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int BOARD_X0 = 240;
  localparam int BOARD_Y0 = 80;
  localparam int CELL_LOG2 = 4;
  localparam int DW = 3;
  localparam int CELLS = ROWS * COLS;
  localparam int CELL_PX = 1 << CELL_LOG2;
  // Slots lead each cell by 3 pixels: address register, RAM read, capture.
  localparam logic [9:0] SLOT_X0 = 10'(BOARD_X0 - 3);
  localparam logic [9:0] Y_TOP = 10'(BOARD_Y0);
  localparam logic [9:0] Y_END = 10'(BOARD_Y0 + ROWS * CELL_PX);
  localparam logic [9:0] X_LAST = 10'(BOARD_X0 + COLS * CELL_PX - 1);
  localparam logic [7:0] LAST_CELL = 8'(CELLS - 1);
  typedef logic [DW-1:0] color_t;
  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK, ST_CLEAR} arb_state_t;
endpackage

// File: rtl/render_addr_gen.sv
// render_addr_gen: flags the render prefetch slot and forms the cell address row*10+k
module render_addr_gen
  import petris_pkg::*;
(
  input  logic [9:0] count_x,
  input  logic [9:0] count_y,
  output logic       slot,
  output logic [7:0] addr
);
  logic [9:0] dx, dy;
  logic [4:0] row;
  logic [3:0] col;
  always_comb begin
    dx = count_x - SLOT_X0;
    dy = count_y - Y_TOP;
    row = 5'(dy >> CELL_LOG2);
    col = 4'(dx >> CELL_LOG2);
    slot = count_x >= SLOT_X0 && dx[3:0] == 4'd0 && (dx >> CELL_LOG2) < 10'(COLS)
        && count_y >= Y_TOP && count_y < Y_END;
    addr = {row, 3'b000} + {2'b00, row, 1'b0} + {4'b0000, col};
  end
endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the board RAM between renderer prefetch, game accesses and board clear
module board_mem_arbiter
  import petris_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic [9:0]    count_x,
  input  logic [9:0]    count_y,
  input  logic          clear_req,
  output logic          clear_busy,
  input  logic          game_req,
  input  logic          game_we,
  input  logic [7:0]    game_addr,
  input  logic [DW-1:0] game_wdata,
  output logic          game_ack,
  output logic [DW-1:0] game_rdata,
  output logic [7:0]    mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] cell_color,
  output logic          board_active
);
  arb_state_t state, state_nx;
  logic       slot, accept, clr_start, clr_step, addr_ok, zero_rd;
  logic [7:0] render_addr, clr_cnt;
  logic [1:0] slot_d;
  color_t     rd_next;

  render_addr_gen u_gen (
    .count_x(count_x),
    .count_y(count_y),
    .slot   (slot),
    .addr   (render_addr)
  );

  assign addr_ok = game_addr < 8'(CELLS);
  assign game_ack = state == ST_ACK;
  assign clear_busy = state == ST_CLEAR;
  assign rd_next = zero_rd ? '0 : mem_rdata;

  always_ff @(posedge clock or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    accept = 1'b0;
    clr_start = 1'b0;
    clr_step = 1'b0;
    case (state)
      ST_IDLE: begin
        clr_start = !slot && clear_req;
        accept = !slot && !clear_req && game_req;
        state_nx = clr_start ? ST_CLEAR : accept ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT:  state_nx = ST_ACK;
      ST_ACK:   state_nx = ST_IDLE;
      ST_CLEAR: begin
        clr_step = !slot;
        state_nx = (clr_step && clr_cnt == LAST_CELL) ? ST_IDLE : ST_CLEAR;
      end
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The render slot may overwrite the port mid-transaction: the RAM has already sampled the game address.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mem_addr <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      clr_cnt <= '0;
      zero_rd <= 1'b0;
      game_rdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (slot) mem_addr <= render_addr;
      else if (accept) begin
        if (addr_ok) mem_addr <= game_addr;
        mem_we <= game_we && addr_ok;
        mem_wdata <= game_wdata;
        zero_rd <= game_we || !addr_ok;
      end else if (clr_step) begin
        mem_addr <= clr_cnt;
        mem_we <= 1'b1;
        mem_wdata <= '0;
      end
      clr_cnt <= clr_start ? '0 : clr_step ? clr_cnt + 8'd1 : clr_cnt;
      if (state == ST_WAIT) game_rdata <= rd_next;
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      slot_d <= '0;
      cell_color <= '0;
      board_active <= 1'b0;
    end else begin
      slot_d <= {slot_d[0], slot};
      if (slot_d[1]) begin
        cell_color <= mem_rdata;
        board_active <= 1'b1;
      end else if (count_x == X_LAST) begin
        cell_color <= '0;
        board_active <= 1'b0;
      end
    end
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: scoreboard bench driving raster counters and a behavioural board RAM
`timescale 1ns/1ps
module tb_board_mem_arbiter;
  logic       clock = 1'b0, reset = 1'b1;
  logic [9:0] count_x = '0, count_y = '0;
  logic       clear_req = 1'b0, game_req = 1'b0, game_we = 1'b0;
  logic [7:0] game_addr = '0;
  logic [2:0] game_wdata = '0;
  logic       clear_busy, game_ack, mem_we, board_active;
  logic [7:0] mem_addr;
  logic [2:0] game_rdata, mem_wdata, mem_rdata, cell_color;
  logic [2:0] ram [256];
  logic [2:0] shadow [200];
  logic [2:0] exp_q [$];
  int         n_chk = 0, n_pass = 0;
  bit         sweep = 0, rchk = 0;
  int         lat, we_cnt, n_busy, n_sl, any_ack;
  logic [7:0] ma1, ma2;
  bit         pre_busy, pre_slot, saw_busy;

  board_mem_arbiter dut (
    .clock(clock), .reset(reset), .count_x(count_x), .count_y(count_y),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr), .game_wdata(game_wdata),
    .game_ack(game_ack), .game_rdata(game_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cell_color(cell_color), .board_active(board_active)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 3'((i % 7) + 1);
    mem_rdata <= '0;
    forever begin
      @(posedge clock);
      mem_rdata <= ram[mem_addr];
      if (mem_we) ram[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit tb_slot(input int x, input int y);
    return y >= 80 && y < 400 && x >= 237 && x <= 381 && (x - 237) % 16 == 0;
  endfunction

  task automatic render_check();
    int p, y;
    bit act;
    logic [2:0] c;
    p = int'(count_x);
    y = int'(count_y);
    act = y >= 80 && y < 400 && p >= 240 && p < 400;
    c = act ? shadow[((y - 80) / 16) * 10 + (p - 240) / 16] : 3'd0;
    chk("render_active", board_active, act);
    chk("render_color", cell_color, c);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (sweep) begin
      if (count_x == 10'd799) begin
        count_x = '0;
        count_y = (count_y == 10'd524) ? 10'd0 : count_y + 10'd1;
      end else count_x = count_x + 10'd1;
    end
    if (rchk) render_check();
  endtask

  task automatic sweep_to(input int x);
    for (int i = 0; i < 2000 && count_x != 10'(x); i++) tick();
  endtask

  task automatic game_txn(input logic we, input logic [7:0] addr, input logic [2:0] wd, input int exp_lat);
    bit ok;
    ok = addr < 8'd200;
    exp_q.push_back((we || !ok) ? 3'd0 : shadow[addr]);
    if (we && ok) shadow[addr] = wd;
    game_req = 1'b1;
    game_we = we;
    game_addr = addr;
    game_wdata = wd;
    lat = 0;
    we_cnt = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (mem_we) we_cnt++;
      if (i == 1) ma1 = mem_addr;
      if (i == 2) ma2 = mem_addr;
      if (game_ack) lat = i;
    end
    game_req = 1'b0;
    chk("game_ack", game_ack, 1);
    chk("game_rdata", game_rdata, exp_q.pop_front());
    chk("game_latency", lat, exp_lat);
    chk("game_mem_we", we_cnt, (we && ok) ? 1 : 0);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 200; i++) shadow[i] = '0;
    tick();
    tick();
    chk("reset_outs", {clear_busy, game_ack, game_rdata, mem_addr, mem_we, mem_wdata, cell_color, board_active}, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) game_txn(1'b1, 8'(i), 3'((i * 3 + 5) % 8), 3);
    game_txn(1'b1, 8'd57, 3'd6, 3);
    game_txn(1'b0, 8'd57, 3'd0, 3);
    game_txn(1'b0, 8'd0, 3'd0, 3);
    rchk = 1;
    sweep = 1;
    count_y = 10'd79;
    count_x = 10'd230;
    sweep_to(405);
    count_y = 10'd80;
    count_x = 10'd230;
    sweep_to(238);
    chk("render_addr_slot0", mem_addr, 0);
    sweep_to(405);
    count_y = 10'd96;
    count_x = 10'd230;
    sweep_to(253);
    game_txn(1'b0, 8'd57, 3'd0, 4);
    chk("collide_render_first", ma1, 11);
    chk("collide_game_next", ma2, 57);
    sweep_to(405);
    rchk = 0;
    count_y = 10'd200;
    count_x = 10'd230;
    for (int i = 0; i < 200; i++) shadow[i] = '0;
    clear_req = 1'b1;
    game_req = 1'b1;
    game_we = 1'b0;
    game_addr = 8'd57;
    exp_q.push_back(3'd0);
    n_busy = 0;
    n_sl = 0;
    lat = 0;
    saw_busy = 0;
    for (int i = 0; i < 2000 && lat == 0; i++) begin
      pre_busy = clear_busy;
      pre_slot = tb_slot(int'(count_x), int'(count_y));
      tick();
      clear_req = 1'b0;
      if (clear_busy) saw_busy = 1;
      if (pre_busy) begin
        n_busy++;
        if (pre_slot) n_sl++;
      end
      if (game_ack) lat = i + 1;
    end
    game_req = 1'b0;
    chk("clear_ack", game_ack, 1);
    chk("clear_ack_after_busy", {saw_busy, clear_busy}, 2'b10);
    chk("clear_rdata", game_rdata, exp_q.pop_front());
    chk("clear_len", n_busy, 200 + n_sl);
    chk("clear_slots_seen", n_sl, 10);
    tick();
    sweep = 0;
    count_y = '0;
    count_x = '0;
    for (int i = 0; i < 200; i++) game_txn(1'b0, 8'(i), 3'd0, 3);
    game_txn(1'b1, 8'd200, 3'd7, 3);
    game_txn(1'b0, 8'd200, 3'd0, 3);
    game_txn(1'b1, 8'd199, 3'd4, 3);
    game_txn(1'b0, 8'd199, 3'd0, 3);
    game_txn(1'b1, 8'd0, 3'd5, 3);
    sweep = 1;
    count_y = 10'd80;
    count_x = 10'd230;
    sweep_to(244);
    chk("pre_reset_color", cell_color, shadow[0]);
    game_req = 1'b1;
    game_we = 1'b0;
    game_addr = 8'd0;
    tick();
    tick();
    chk("pre_reset_noack", game_ack, 0);
    #2 reset = 1'b1;
    #1;
    chk("reset_wait_outs", {clear_busy, game_ack, game_rdata, mem_addr, mem_we, mem_wdata, cell_color, board_active}, 0);
    game_req = 1'b0;
    sweep = 0;
    count_y = '0;
    count_x = '0;
    tick();
    reset = 1'b0;
    any_ack = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (game_ack) any_ack++;
    end
    chk("reset_no_ack", any_ack, 0);
    game_txn(1'b0, 8'd0, 3'd0, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
